// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP register-format constants, decoded-field struct and class-mask helper
// Contents: format codes, RISC-V class-bit indices, F32/F64 field widths,
//           fp_fields_t (flags from the decode stage), fp_class_mask().
package fp_pkg;

  localparam logic [1:0] FMT_F32 = 2'd0;
  localparam logic [1:0] FMT_F64 = 2'd1;

  localparam int CLS_W = 10;

  localparam logic [3:0] CLS_NINF  = 4'd0;
  localparam logic [3:0] CLS_NNORM = 4'd1;
  localparam logic [3:0] CLS_NSUB  = 4'd2;
  localparam logic [3:0] CLS_NZERO = 4'd3;
  localparam logic [3:0] CLS_PZERO = 4'd4;
  localparam logic [3:0] CLS_PSUB  = 4'd5;
  localparam logic [3:0] CLS_PNORM = 4'd6;
  localparam logic [3:0] CLS_PINF  = 4'd7;
  localparam logic [3:0] CLS_SNAN  = 4'd8;
  localparam logic [3:0] CLS_QNAN  = 4'd9;

  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F64_EXP_W = 11;
  localparam int F64_MAN_W = 52;

  typedef struct packed {
    logic sign;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic man_msb;
    logic box_fail;
    logic illegal;
  } fp_fields_t;

  // One-hot class mask from decoded flags; all-zero for an illegal format.
  function automatic logic [CLS_W-1:0] fp_class_mask(input fp_fields_t f);
    logic [CLS_W-1:0] m;
    m = '0;
    if (f.illegal) begin
      m = '0;
    end else if (f.box_fail) begin
      // A badly boxed F32 reads back as the canonical quiet NaN.
      m[CLS_QNAN] = 1'b1;
    end else if (f.exp_ones && !f.man_zero) begin
      if (f.man_msb) m[CLS_QNAN] = 1'b1;
      else           m[CLS_SNAN] = 1'b1;
    end else if (f.exp_ones) begin
      if (f.sign) m[CLS_NINF] = 1'b1;
      else        m[CLS_PINF] = 1'b1;
    end else if (f.exp_zero && f.man_zero) begin
      if (f.sign) m[CLS_NZERO] = 1'b1;
      else        m[CLS_PZERO] = 1'b1;
    end else if (f.exp_zero) begin
      if (f.sign) m[CLS_NSUB] = 1'b1;
      else        m[CLS_PSUB] = 1'b1;
    end else begin
      if (f.sign) m[CLS_NNORM] = 1'b1;
      else        m[CLS_PNORM] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// rtl/fp_class_decode.sv - combinational F32/F64 operand field decoder
// Ports: data   [63:0] operand (F32 NaN-boxed in [31:0])
//        fmt    [1:0]  0 = F32, 1 = F64, 2/3 illegal
//        fields        decoded flags (fp_fields_t)
module fp_class_decode
  import fp_pkg::*;
#(
  parameter bit NANBOX_CHECK = 1'b1
) (
  input  logic [63:0] data,
  input  logic [1:0]  fmt,
  output fp_fields_t  fields
);

  logic [F32_EXP_W-1:0] exp32;
  logic [F32_MAN_W-1:0] man32;
  logic [F64_EXP_W-1:0] exp64;
  logic [F64_MAN_W-1:0] man64;

  assign exp32 = data[F32_MAN_W +: F32_EXP_W];
  assign man32 = data[F32_MAN_W-1:0];
  assign exp64 = data[F64_MAN_W +: F64_EXP_W];
  assign man64 = data[F64_MAN_W-1:0];

  always_comb begin
    fields         = '0;
    fields.illegal = (fmt != FMT_F32) && (fmt != FMT_F64);
    if (fmt == FMT_F32) begin
      fields.sign     = data[31];
      fields.exp_ones = &exp32;
      fields.exp_zero = ~|exp32;
      fields.man_zero = ~|man32;
      fields.man_msb  = man32[F32_MAN_W-1];
      fields.box_fail = NANBOX_CHECK && (data[63:32] != 32'hFFFF_FFFF);
    end else begin
      // Illegal formats also decode as F64; the illegal flag overrides the class.
      fields.sign     = data[63];
      fields.exp_ones = &exp64;
      fields.exp_zero = ~|exp64;
      fields.man_zero = ~|man64;
      fields.man_msb  = man64[F64_MAN_W-1];
    end
  end

endmodule

// File: rtl/fp_class.sv
// rtl/fp_class.sv - two-stage pipelined FCLASS.S/FCLASS.D unit with valid/ready handshake
// Ports: clk, rst_n (async, active low)
//        fp_class_i_valid / fp_class_o_ready / fp_class_i_data[63:0] / fp_class_i_fmt[1:0]  operand side
//        fp_class_o_valid / fp_class_i_ready / fp_class_o_result[63:0]                      result side
//        result carries the class mask in [9:0], upper bits zero
module fp_class
  import fp_pkg::*;
#(
  parameter bit NANBOX_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fp_class_i_valid,
  output logic        fp_class_o_ready,
  input  logic [63:0] fp_class_i_data,
  input  logic [1:0]  fp_class_i_fmt,
  output logic        fp_class_o_valid,
  input  logic        fp_class_i_ready,
  output logic [63:0] fp_class_o_result
);

  fp_fields_t       dec_fields;
  fp_fields_t       s1_fields;
  logic             s1_valid;
  logic             s2_valid;
  logic [CLS_W-1:0] s2_mask;
  logic             s1_en;
  logic             s2_en;
  logic             in_xfer;

  fp_class_decode #(
    .NANBOX_CHECK (NANBOX_CHECK)
  ) u_decode (
    .data   (fp_class_i_data),
    .fmt    (fp_class_i_fmt),
    .fields (dec_fields)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  // Ready therefore depends combinationally on downstream ready.
  assign s2_en            = !s2_valid || fp_class_i_ready;
  assign s1_en            = !s1_valid || s2_en;
  assign fp_class_o_ready = s1_en;
  assign in_xfer          = fp_class_i_valid && s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fields <= '0;
    end else if (s1_en) begin
      s1_valid <= in_xfer;
      if (in_xfer) s1_fields <= dec_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mask  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_mask <= fp_class_mask(s1_fields);
    end
  end

  assign fp_class_o_valid  = s2_valid;
  assign fp_class_o_result = {{(64-CLS_W){1'b0}}, s2_mask};

endmodule

// File: tb/tb_fp_class.sv
// tb/tb_fp_class.sv - self-checking bench for fp_class (vector table, corner sequences, random traffic)
module tb_fp_class;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [63:0] i_data = '0;
  logic [1:0]  i_fmt = '0;
  logic        o_ready, o_valid, o_ready_nb0, o_valid_nb0;
  logic [63:0] o_result, o_result_nb0;

  always #5 clk = ~clk;

  fp_class #(.NANBOX_CHECK(1'b1)) dut (
    .clk (clk), .rst_n (rst_n),
    .fp_class_i_valid (i_valid), .fp_class_o_ready (o_ready),
    .fp_class_i_data (i_data), .fp_class_i_fmt (i_fmt),
    .fp_class_o_valid (o_valid), .fp_class_i_ready (i_ready),
    .fp_class_o_result (o_result)
  );

  fp_class #(.NANBOX_CHECK(1'b0)) dut_nb0 (
    .clk (clk), .rst_n (rst_n),
    .fp_class_i_valid (i_valid), .fp_class_o_ready (o_ready_nb0),
    .fp_class_i_data (i_data), .fp_class_i_fmt (i_fmt),
    .fp_class_o_valid (o_valid_nb0), .fp_class_i_ready (i_ready),
    .fp_class_o_result (o_result_nb0)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference classifier straight from the IEEE field rules.
  function automatic logic [9:0] ref_class(input logic [63:0] d, input logic [1:0] f, input bit nb);
    longint unsigned e, emax, m, q;
    bit s;
    int cls;
    if (f > 2'd1) return 10'd0;
    if (f == 2'd0) begin
      if (nb && ((d >> 32) != 64'hFFFF_FFFF)) return 10'h200;
      s = d[31];
      e = (d >> 23) % 256;
      emax = 255;
      m = d % (64'd1 << 23);
      q = m >> 22;
    end else begin
      s = d[63];
      e = (d >> 52) % 2048;
      emax = 2047;
      m = d % (64'd1 << 52);
      q = m >> 51;
    end
    if (e == emax)   cls = (m == 0) ? (s ? 0 : 7) : (q != 0 ? 9 : 8);
    else if (e == 0) cls = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else             cls = s ? 1 : 6;
    return 10'(1 << cls);
  endfunction

  typedef struct {
    logic [9:0] e1;
    logic [9:0] e0;
    int         cyc;
    bit         strict;
  } exp_t;

  exp_t sb[$];
  logic [9:0] cur_e1 = '0, cur_e0 = '0;
  bit strict_lat = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Scoreboard: record accepted operands, check results in order on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got result %h expected no valid output", o_result);
        end else begin
          e = sb.pop_front();
          chk("result", o_result, {54'd0, e.e1});
          chk("result_nb0", o_result_nb0, {54'd0, e.e0});
          if (e.strict) chk("latency", 64'(cyc - e.cyc), 64'd2);
          n_out++;
        end
      end
      if (i_valid && o_ready) sb.push_back('{e1: cur_e1, e0: cur_e0, cyc: cyc, strict: strict_lat});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the operand is accepted.
  task automatic send_op(input logic [63:0] d, input logic [1:0] f, input logic [9:0] e1, input logic [9:0] e0);
    int n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_fmt   = f;
    cur_e1  = e1;
    cur_e0  = e0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 200);
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got o_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    i_valid = 1'b0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand();
    logic [63:0] d;
    logic [1:0]  f;
    int r, kind;
    r = $urandom_range(0, 9);
    f = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
    d = {$urandom, $urandom};
    kind = $urandom_range(0, 4);
    if (f == 2'd0) begin
      if ($urandom_range(0, 7) != 0) d[63:32] = 32'hFFFF_FFFF;
      case (kind)
        1: d[30:23] = 8'hFF;
        2: d[30:0]  = {8'hFF, 23'd0};
        3: d[30:23] = 8'h00;
        4: d[30:0]  = 31'd0;
        default: ;
      endcase
    end else begin
      case (kind)
        1: d[62:52] = 11'h7FF;
        2: d[62:0]  = {11'h7FF, 52'd0};
        3: d[62:52] = 11'h000;
        4: d[62:0]  = 63'd0;
        default: ;
      endcase
    end
    send_op(d, f, ref_class(d, f, 1'b1), ref_class(d, f, 1'b0));
    if ($urandom_range(0, 3) == 0) begin
      i_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [63:0] data;
    logic [9:0]  e1;
    logic [9:0]  e0;
  } vec_t;

  vec_t tbl[$];
  int n0;

  initial begin
    tbl.push_back('{2'd0, 64'hFFFFFFFF_3F800000, 10'h040, 10'h040});
    tbl.push_back('{2'd1, 64'h80000000_00000000, 10'h008, 10'h008});
    tbl.push_back('{2'd1, 64'h00000000_00000001, 10'h020, 10'h020});
    tbl.push_back('{2'd1, 64'hFFF00000_00000000, 10'h001, 10'h001});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_7F800001, 10'h100, 10'h100});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_7FC00000, 10'h200, 10'h200});
    tbl.push_back('{2'd1, 64'h7FF80000_00000000, 10'h200, 10'h200});
    tbl.push_back('{2'd0, 64'h00000000_3F800000, 10'h200, 10'h040});
    tbl.push_back('{2'd2, 64'h3FF00000_00000000, 10'h000, 10'h000});
    tbl.push_back('{2'd1, 64'h3FF00000_00000000, 10'h040, 10'h040});
    tbl.push_back('{2'd3, 64'hFFFFFFFF_3F800000, 10'h000, 10'h000});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_80000000, 10'h008, 10'h008});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_00000001, 10'h020, 10'h020});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_807FFFFF, 10'h004, 10'h004});
    tbl.push_back('{2'd0, 64'hFFFFFFFF_FF800000, 10'h001, 10'h001});
    tbl.push_back('{2'd1, 64'hC0000000_00000000, 10'h002, 10'h002});
    tbl.push_back('{2'd0, 64'h00000000_FF800000, 10'h200, 10'h001});
    tbl.push_back('{2'd0, 64'h12345678_7F800001, 10'h200, 10'h100});

    // Reset state
    #2;
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_result", o_result, 64'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, o_ready}, 64'd1);
    chk("valid_after_reset", {63'd0, o_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Vector table at full rate: every result exactly two cycles after acceptance
    strict_lat = 1'b1;
    foreach (tbl[i]) send_op(tbl[i].data, tbl[i].fmt, tbl[i].e1, tbl[i].e0);
    drain("table_drain");
    strict_lat = 1'b0;
    chk("table_count", 64'(n_out), 64'(tbl.size()));

    // Backpressure: two held internally, third stalls, head result stable
    @(negedge clk);
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    n0 = n_out;
    send_op(64'h3FF00000_00000000, 2'd1, 10'h040, 10'h040);
    send_op(64'hFFFFFFFF_BF800000, 2'd0, 10'h002, 10'h002);
    i_valid = 1'b1;
    i_data  = 64'hFFF80000_00000000;
    i_fmt   = 2'd1;
    cur_e1  = 10'h200;
    cur_e0  = 10'h200;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", {63'd0, o_ready}, 64'd0);
      chk("bp_valid_held", {63'd0, o_valid}, 64'd1);
      chk("bp_result_held", o_result, 64'h040);
    end
    ready_force = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_ready && n < 20);
      chk("bp_ready_recovers", {63'd0, o_ready}, 64'd1);
    end
    @(posedge clk);
    #1;
    drain("bp_drain");
    chk("bp_drain_count", 64'(n_out - n0), 64'd3);

    // Randomized traffic with random downstream stalls
    @(negedge clk);
    rand_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 300; k++) send_rand();
    i_valid = 1'b0;
    @(negedge clk);
    rand_ready = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    drain("rand_drain");

    // Reset with both stages full
    @(negedge clk);
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_op(64'hFFFFFFFF_3F800000, 2'd0, 10'h040, 10'h040);
    send_op(64'h80000000_00000000, 2'd1, 10'h008, 10'h008);
    i_valid = 1'b0;
    @(negedge clk);
    chk("full_valid", {63'd0, o_valid}, 64'd1);
    chk("full_ready_low", {63'd0, o_ready}, 64'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_valid", {63'd0, o_valid}, 64'd0);
    chk("async_reset_result", o_result, 64'd0);
    @(negedge clk);
    ready_force = 1'b1;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_stale_valid", {63'd0, o_valid}, 64'd0);
    end
    chk("ready_after_midreset", {63'd0, o_ready}, 64'd1);
    @(posedge clk);
    #1;
    n0 = n_out;
    send_op(64'hC0000000_00000000, 2'd1, 10'h002, 10'h002);
    drain("post_reset_drain");
    chk("post_reset_count", 64'(n_out - n0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
